// File: rtl/w0rm_mem_arbiter_pkg.sv
// w0rm_mem_arbiter_pkg: FSM states and timeout counter width shared by the W0RM bus arbiter.
package w0rm_mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_e;
  localparam int CNT_W = 8;
endpackage

// File: rtl/w0rm_rr_arbiter2.sv
// w0rm_rr_arbiter2: two-way round-robin pick; the master that was not granted last wins a tie.
module w0rm_rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o
);
  assign gnt_o[0] = req_i[0] & (~req_i[1] | last_grant_i);
  assign gnt_o[1] = req_i[1] & (~req_i[0] | ~last_grant_i);
endmodule

// File: rtl/w0rm_mem_arbiter.sv
// w0rm_mem_arbiter: shares the W0RM data bus between two masters, one transaction outstanding,
// with response routing back to the issuer and timeout error completion.
module w0rm_mem_arbiter
  import w0rm_mem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic                  core_clk,
  input  logic                  reset_n,
  input  logic                  m0_valid_i,
  input  logic                  m0_read_i,
  input  logic                  m0_write_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_data_i,
  output logic                  m0_accept_o,
  output logic                  m0_valid_o,
  output logic [DATA_WIDTH-1:0] m0_data_o,
  output logic                  m0_err_o,
  input  logic                  m1_valid_i,
  input  logic                  m1_read_i,
  input  logic                  m1_write_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_data_i,
  output logic                  m1_accept_o,
  output logic                  m1_valid_o,
  output logic [DATA_WIDTH-1:0] m1_data_o,
  output logic                  m1_err_o,
  output logic                  s_valid_o,
  output logic                  s_read_o,
  output logic                  s_write_o,
  output logic [ADDR_WIDTH-1:0] s_addr_o,
  output logic [DATA_WIDTH-1:0] s_data_o,
  input  logic                  s_valid_i,
  input  logic [DATA_WIDTH-1:0] s_data_i
);
  state_e                state_q, state_d;
  logic                  last_q, last_d, own_q, own_d;
  logic                  sv_q, sv_d, rd_q, rd_d, wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            acc_q, acc_d, vld_q, vld_d, err_q, err_d, gnt;
  logic [DATA_WIDTH-1:0] rdat_q [2];
  logic [DATA_WIDTH-1:0] rdat_d [2];

  w0rm_rr_arbiter2 u_arb (
    .req_i        ({m1_valid_i, m0_valid_i}),
    .last_grant_i (last_q),
    .gnt_o        (gnt)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    own_d   = own_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdat_d  = rdat_q;
    sv_d    = 1'b0;
    acc_d   = 2'b00;
    vld_d   = 2'b00;
    case (state_q)
      IDLE: if (|gnt) begin
        state_d = ISSUE;
        own_d   = gnt[1];
        last_d  = gnt[1];
        rd_d    = gnt[1] ? m1_read_i  : m0_read_i;
        wr_d    = gnt[1] ? m1_write_i : m0_write_i;
        addr_d  = gnt[1] ? m1_addr_i  : m0_addr_i;
        wdat_d  = gnt[1] ? m1_data_i  : m0_data_i;
        sv_d    = 1'b1;
        acc_d   = gnt;
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      // A response arriving on the timeout cycle still wins over the error.
      WAIT: if (s_valid_i) begin
        state_d       = RESP;
        vld_d[own_q]  = 1'b1;
        err_d[own_q]  = 1'b0;
        rdat_d[own_q] = s_data_i;
      end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
        state_d       = RESP;
        vld_d[own_q]  = 1'b1;
        err_d[own_q]  = 1'b1;
        rdat_d[own_q] = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge core_clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      own_q   <= 1'b0;
      sv_q    <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      vld_q   <= '0;
      err_q   <= '0;
      rdat_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      own_q   <= own_d;
      sv_q    <= sv_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
    end
  end

  assign m0_accept_o = acc_q[0];
  assign m1_accept_o = acc_q[1];
  assign m0_valid_o  = vld_q[0];
  assign m1_valid_o  = vld_q[1];
  assign m0_err_o    = err_q[0];
  assign m1_err_o    = err_q[1];
  assign m0_data_o   = rdat_q[0];
  assign m1_data_o   = rdat_q[1];
  assign s_valid_o   = sv_q;
  assign s_read_o    = rd_q;
  assign s_write_o   = wr_q;
  assign s_addr_o    = addr_q;
  assign s_data_o    = wdat_q;
endmodule

// File: tb/tb_w0rm_mem_arbiter.sv
// tb_w0rm_mem_arbiter: directed vectors for the two-master W0RM bus arbiter.
module tb_w0rm_mem_arbiter;
  logic        core_clk = 1'b0;
  logic        reset_n;
  logic        m0_valid_i, m0_read_i, m0_write_i, m1_valid_i, m1_read_i, m1_write_i;
  logic [31:0] m0_addr_i, m0_data_i, m1_addr_i, m1_data_i;
  logic        m0_accept_o, m0_valid_o, m0_err_o, m1_accept_o, m1_valid_o, m1_err_o;
  logic [31:0] m0_data_o, m1_data_o;
  logic        s_valid_o, s_read_o, s_write_o, s_valid_i;
  logic [31:0] s_addr_o, s_data_o, s_data_i;
  int          n_cmp = 0;
  int          n_bad = 0;

  w0rm_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(15)) dut (
    .core_clk(core_clk), .reset_n(reset_n),
    .m0_valid_i(m0_valid_i), .m0_read_i(m0_read_i), .m0_write_i(m0_write_i),
    .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_accept_o(m0_accept_o),
    .m0_valid_o(m0_valid_o), .m0_data_o(m0_data_o), .m0_err_o(m0_err_o),
    .m1_valid_i(m1_valid_i), .m1_read_i(m1_read_i), .m1_write_i(m1_write_i),
    .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_accept_o(m1_accept_o),
    .m1_valid_o(m1_valid_o), .m1_data_o(m1_data_o), .m1_err_o(m1_err_o),
    .s_valid_o(s_valid_o), .s_read_o(s_read_o), .s_write_o(s_write_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_valid_i(s_valid_i), .s_data_i(s_data_i)
  );

  always #5 core_clk = ~core_clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge core_clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic run_xact(input string tag, input bit em, input logic [31:0] ea,
                          input int lat, input logic [31:0] rd, input bit drop);
    int k = 0;
    while (!s_valid_o && k < 20) begin
      tick();
      k++;
    end
    chk({tag, ".issue"}, 32'(s_valid_o), 32'd1);
    chk({tag, ".acc"}, 32'({m1_accept_o, m0_accept_o}), em ? 32'd2 : 32'd1);
    chk({tag, ".addr"}, s_addr_o, ea);
    if (drop) begin
      if (em) m1_valid_i = 1'b0;
      else    m0_valid_i = 1'b0;
    end
    repeat (lat) tick();
    s_valid_i = 1'b1;
    s_data_i  = rd;
    tick();
    s_valid_i = 1'b0;
    chk({tag, ".vld"}, 32'({m1_valid_o, m0_valid_o}), em ? 32'd2 : 32'd1);
    chk({tag, ".data"}, em ? m1_data_o : m0_data_o, rd);
    chk({tag, ".err"}, 32'(em ? m1_err_o : m0_err_o), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    {m0_valid_i, m0_read_i, m0_write_i, m1_valid_i, m1_read_i, m1_write_i, s_valid_i} = '0;
    m0_addr_i = '0; m0_data_i = '0; m1_addr_i = '0; m1_data_i = '0; s_data_i = '0;
    tick();
    tick();
    reset_n = 1'b1;
    chk("rst.outs", 32'({m0_accept_o, m0_valid_o, m0_err_o, m1_accept_o, m1_valid_o, m1_err_o,
                         s_valid_o, s_read_o, s_write_o}), 32'd0);
    chk("rst.addr", s_addr_o, 32'd0);
    // single read from m0, slave answers two cycles after the bus strobe
    m0_valid_i = 1'b1; m0_read_i = 1'b1; m0_addr_i = 32'h10;
    run_xact("t1", 1'b0, 32'h10, 2, 32'hDEADBEEF, 1'b1);
    chk("t1.m1quiet", 32'({m1_valid_o, m1_err_o, m1_accept_o}), 32'd0);
    chk("t1.m1data", m1_data_o, 32'd0);
    tick();
    chk("t1.vlddrop", 32'(m0_valid_o), 32'd0);
    chk("t1.hold", m0_data_o, 32'hDEADBEEF);
    // simultaneous requests alternate starting with m0 after reset
    do_reset();
    m0_valid_i = 1'b1; m0_addr_i = 32'h100;
    m1_valid_i = 1'b1; m1_read_i = 1'b1; m1_addr_i = 32'h200;
    run_xact("t2a", 1'b0, 32'h100, 1, 32'h11111111, 1'b1);
    run_xact("t2b", 1'b1, 32'h200, 3, 32'h22222222, 1'b1);
    tick();
    m0_valid_i = 1'b1; m1_valid_i = 1'b1;
    run_xact("t2c", 1'b0, 32'h100, 1, 32'h33333333, 1'b1);
    run_xact("t2d", 1'b1, 32'h200, 1, 32'h44444444, 1'b1);
    tick();
    // m1 write that never receives a response
    m1_valid_i = 1'b1; m1_read_i = 1'b0; m1_write_i = 1'b1;
    m1_addr_i = 32'h80000080; m1_data_i = 32'h000000A5;
    tick();
    chk("t3.acc", 32'({m1_accept_o, m0_accept_o}), 32'd2);
    chk("t3.rw", 32'({s_read_o, s_write_o}), 32'd1);
    chk("t3.addr", s_addr_o, 32'h80000080);
    chk("t3.wdata", s_data_o, 32'h000000A5);
    m1_valid_i = 1'b0;
    repeat (15) tick();
    chk("t3.early", 32'(m1_valid_o), 32'd0);
    tick();
    chk("t3.vld", 32'(m1_valid_o), 32'd1);
    chk("t3.err", 32'(m1_err_o), 32'd1);
    chk("t3.data", m1_data_o, 32'd0);
    tick();
    s_valid_i = 1'b1; s_data_i = 32'hCAFEF00D;
    tick();
    s_valid_i = 1'b0;
    chk("t3.stray", 32'({m0_valid_o, m1_valid_o, s_valid_o}), 32'd0);
    chk("t3.straydata", m1_data_o, 32'd0);
    chk("t3.holdaddr", s_addr_o, 32'h80000080);
    // response on the very cycle the timeout would fire
    m0_valid_i = 1'b1; m0_read_i = 1'b1; m0_write_i = 1'b0; m0_addr_i = 32'h40;
    run_xact("t4", 1'b0, 32'h40, 15, 32'h12345678, 1'b1);
    tick();
    // reset in the middle of WAIT
    m1_valid_i = 1'b1; m1_read_i = 1'b1; m1_write_i = 1'b0; m1_addr_i = 32'h300;
    tick();
    chk("t5.acc", 32'(m1_accept_o), 32'd1);
    m1_valid_i = 1'b0;
    tick();
    reset_n = 1'b0; s_valid_i = 1'b1; s_data_i = 32'h00000BAD;
    tick();
    reset_n = 1'b1;
    chk("t5.zero", 32'(|{m0_accept_o, m0_valid_o, m0_err_o, m0_data_o, m1_accept_o, m1_valid_o,
                         m1_err_o, m1_data_o, s_valid_o, s_read_o, s_write_o, s_addr_o, s_data_o}), 32'd0);
    tick();
    s_valid_i = 1'b0;
    chk("t5.late", 32'({m0_valid_o, m1_valid_o, s_valid_o}), 32'd0);
    tick();
    chk("t5.idle", 32'({m0_valid_o, m1_valid_o, s_valid_o}), 32'd0);
    // m0 requests continuously while m1 requests three times
    m0_valid_i = 1'b1; m0_addr_i = 32'h100; m1_valid_i = 1'b1; m1_addr_i = 32'h200;
    for (int i = 0; i < 7; i++) begin
      run_xact($sformatf("t6.%0d", i), i[0], i[0] ? 32'h200 : 32'h100, 1, 32'hA0 + 32'(i), i[0]);
      if (i == 1 || i == 3) m1_valid_i = 1'b1;
    end
    m0_valid_i = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
